// File: rtl/debug_pkg.sv
// Shared definitions for the debugger capture path: FSM encoding, default
// buffer depth and the byte-stream widths used by the Ethernet frame builder.
package debug_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DUMP  = 2'd3
    } state_e;

    localparam int DEPTH_DEFAULT = 16;
    localparam int TX_DATA_W     = 8;
    localparam int TX_LAST_W     = 1;

endpackage

// File: rtl/debug_capture_ctrl_ram.sv
// Sample buffer: simple dual-port RAM with one write port and one registered
// read port. Only the read register is reset; the array is not.
module capture_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int W     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q;
    logic [W-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read data holds when no read is issued, which keeps the stream stable under stall.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/debug_capture_ctrl.sv
// Debugger capture controller: circular pre-trigger history, programmable
// post-trigger length, then an oldest-first valid/ready dump of the buffer.
module debug_capture_ctrl
    import debug_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arm,
    input  logic                 abort,
    input  logic [AW-1:0]        post_len,
    input  logic                 trig,
    input  logic [7:0]           trig_data,
    output logic [TX_DATA_W-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 tx_last,
    output logic [1:0]           state,
    output logic                 done
);

    localparam logic [AW:0] FILL_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_LEFT = (AW+1)'(1);

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fill_q, fill_d;
    logic [AW:0]   rd_left_q, rd_left_d;
    logic [AW-1:0] post_cnt_q, post_cnt_d;
    logic [AW-1:0] post_len_q, post_len_d;
    logic          tx_valid_q, tx_valid_d;
    logic          tx_last_q, tx_last_d;
    logic          done_q, done_d;

    logic          we;
    logic          re;
    logic          go_dump;
    logic          accept;

    assign accept = tx_valid_q & tx_ready;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        rd_left_d  = rd_left_q;
        post_cnt_d = post_cnt_q;
        post_len_d = post_len_q;
        tx_valid_d = tx_valid_q;
        tx_last_d  = tx_last_q;
        done_d     = 1'b0;
        we         = 1'b0;
        re         = 1'b0;
        go_dump    = 1'b0;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    post_len_d = post_len;
                    wr_ptr_d   = '0;
                    fill_d     = '0;
                    state_d    = ARMED;
                end
            end
            ARMED, POST: begin
                we       = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                fill_d   = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
                if (state_q == ARMED) begin
                    if (trig) begin
                        post_cnt_d = post_len_q;
                        if (post_len_q == '0) begin
                            go_dump = 1'b1;
                        end else begin
                            state_d = POST;
                        end
                    end
                end else begin
                    post_cnt_d = post_cnt_q - 1'b1;
                    if (post_cnt_q <= AW'(1)) begin
                        go_dump = 1'b1;
                    end
                end
            end
            DUMP: begin
                if (accept && tx_last_q) begin
                    state_d    = IDLE;
                    tx_valid_d = 1'b0;
                    tx_last_d  = 1'b0;
                    done_d     = 1'b1;
                end else if (!tx_valid_q || tx_ready) begin
                    // Next read is issued only when the output slot frees, so the RAM
                    // read register doubles as the held output byte.
                    if (rd_left_q != '0) begin
                        re         = 1'b1;
                        rd_ptr_d   = rd_ptr_q + 1'b1;
                        rd_left_d  = rd_left_q - 1'b1;
                        tx_valid_d = 1'b1;
                        tx_last_d  = (rd_left_q == ONE_LEFT);
                    end else begin
                        tx_valid_d = 1'b0;
                        tx_last_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (go_dump) begin
            state_d   = DUMP;
            rd_ptr_d  = wr_ptr_d - fill_d[AW-1:0];
            rd_left_d = fill_d;
        end

        if (abort) begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            done_d     = 1'b0;
            we         = 1'b0;
            re         = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            rd_left_q  <= '0;
            post_cnt_q <= '0;
            post_len_q <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            rd_left_q  <= rd_left_d;
            post_cnt_q <= post_cnt_d;
            post_len_q <= post_len_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
            done_q     <= done_d;
        end
    end

    capture_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (TX_DATA_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (reset),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata (trig_data),
        .re    (re),
        .raddr (rd_ptr_q),
        .rdata (tx_data)
    );

    assign tx_valid = tx_valid_q;
    assign tx_last  = tx_last_q;
    assign state    = state_q;
    assign done     = done_q;

endmodule

// File: tb/tb_debug_capture_ctrl.sv
// Scoreboard bench for debug_capture_ctrl: stimulus pushes expected dump bytes,
// a negedge monitor pops and compares on every handshake.
module tb_debug_capture_ctrl;

    logic       clk;
    logic       reset;
    logic       arm;
    logic       abort;
    logic [3:0] post_len;
    logic       trig;
    logic [7:0] trig_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;
    logic [1:0] state;
    logic       done;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } item_t;

    item_t exp_q[$];
    int    errors    = 0;
    int    checks    = 0;
    int    done_seen = 0;
    int    done_exp  = 0;

    debug_capture_ctrl #(
        .DEPTH (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .arm       (arm),
        .abort     (abort),
        .post_len  (post_len),
        .trig      (trig),
        .trig_data (trig_data),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_last   (tx_last),
        .state     (state),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Monitor: inputs change at posedge+2, so values at negedge are what the next edge sees.
    initial begin
        logic       ps;
        logic [7:0] pd;
        logic       pl;
        item_t      it;
        ps = 1'b0;
        pd = '0;
        pl = 1'b0;
        forever begin
            @(negedge clk);
            if (ps && reset) begin
                chk("stall_hold", {tx_valid, tx_last, tx_data}, {1'b1, pl, pd});
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", tx_data);
                end else begin
                    it = exp_q.pop_front();
                    chk("tx_data", tx_data, it.d);
                    chk("tx_last", tx_last, it.l);
                end
            end
            if (done) done_seen++;
            ps = tx_valid && !tx_ready;
            pd = tx_data;
            pl = tx_last;
        end
    end

    task automatic capture(input int pl, input int trig_k, input bit bp, input bit ab,
                           input bit arm_post);
        int    n;
        int    fill;
        bit    fin;
        item_t it;
        tx_ready = !bp;
        post_len = 4'(pl);
        arm      = 1'b1;
        cyc();
        arm = 1'b0;
        chk("state_armed", state, 1);

        n    = trig_k + 1 + pl;
        fill = (n > 16) ? 16 : n;
        for (int j = n - fill; j < n; j++) begin
            it.d = 8'(j);
            it.l = (j == n - 1);
            exp_q.push_back(it);
        end

        for (int k = 0; k < n; k++) begin
            trig_data = 8'(k);
            trig      = (k == trig_k);
            if (arm_post && k > trig_k) begin
                arm      = 1'b1;
                post_len = 4'd9;
            end
            cyc();
            if (k < trig_k) chk("state_armed_run", state, 1);
            else if (k < n - 1) chk("state_post", state, 2);
        end
        trig     = 1'b0;
        arm      = 1'b0;
        post_len = 4'(pl);
        chk("state_dump", state, 3);
        chk("valid_latency", tx_valid, 0);
        if (!ab) done_exp++;

        fin = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (state == 2'd0) begin
                fin = 1'b1;
                break;
            end
            if (bp) tx_ready = (i < 6) ? 1'b0 : (i % 2 == 1);
            if (ab && tx_valid && tx_last) begin
                abort = 1'b1;
                cyc();
                abort = 1'b0;
                chk("abort_state", state, 0);
                chk("abort_valid", tx_valid, 0);
                chk("abort_done", done, 0);
                fin = 1'b1;
                break;
            end
            cyc();
        end
        chk("dump_finished", fin, 1);
        tx_ready = 1'b1;
        cyc();
        cyc();
    endtask

    initial begin
        reset     = 1'b1;
        arm       = 1'b0;
        abort     = 1'b0;
        trig      = 1'b0;
        post_len  = '0;
        trig_data = '0;
        tx_ready  = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("rst_state", state, 0);
        chk("rst_outputs", {tx_valid, tx_last, done, tx_data}, 0);
        cyc();
        cyc();
        reset = 1'b1;
        cyc();

        capture(3, 19, 1'b0, 1'b0, 1'b0);  // full pre-history: 0x07..0x16
        capture(2, 2, 1'b0, 1'b0, 1'b0);   // early trigger: 0x00..0x04
        capture(0, 5, 1'b0, 1'b0, 1'b0);   // zero post: 0x00..0x05
        capture(3, 19, 1'b1, 1'b0, 1'b0);  // backpressure
        capture(0, 1, 1'b0, 1'b1, 1'b0);   // abort on final handshake
        capture(3, 19, 1'b0, 1'b0, 1'b1);  // recapture, arm during POST ignored

        // Async reset mid-dump with the output stalled.
        tx_ready  = 1'b0;
        post_len  = '0;
        arm       = 1'b1;
        cyc();
        arm       = 1'b0;
        trig_data = 8'hA5;
        trig      = 1'b1;
        cyc();
        trig = 1'b0;
        cyc();
        cyc();
        chk("stalled_valid", tx_valid, 1);
        reset = 1'b0;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_outputs", {tx_valid, tx_last, done, tx_data}, 0);
        cyc();
        reset    = 1'b1;
        tx_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            trig      = 1'b1;
            trig_data = 8'(k + 8'h40);
            cyc();
            chk("trig_no_arm", {state, tx_valid}, 0);
        end
        trig = 1'b0;
        cyc();
        cyc();

        chk("queue_empty", exp_q.size(), 0);
        chk("done_count", done_seen, done_exp);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
